// File: rtl/io_responder.sv
// Memory-mapped IO responder for the Raisin64 external data bus: scratch, timer,
// console TX FIFO and status registers behind a 32-byte window with programmable wait states.
module io_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'hFFFF_FFFF_FFFF_FF00,
    parameter int          WAIT_STATES = 1,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_dout,
    input  logic        mem_dout_write,
    input  logic        mem_addr_valid,
    output logic [63:0] mem_din,
    output logic        mem_din_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] OFF_SCRATCH = 2'd0;
    localparam logic [1:0] OFF_TIMER   = 2'd1;
    localparam logic [1:0] OFF_TX      = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_TURN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       off_q, off_d;
    logic             wr_q, wr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [3:0]       wait_q, wait_d;
    logic [63:0]      rdata_q, rdata_d;
    logic [63:0]      scratch_q, scratch_d;
    logic [63:0]      timer_q, timer_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        sel;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] status_word;
    logic [1:0]  cur_off;
    logic        cur_wr;
    logic [63:0] read_val;
    logic        commit;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[2:0];

    always_comb begin
        sel         = mem_addr_valid && (mem_addr[63:5] == BASE_ADDR[63:5]);
        fifo_full   = (count_q == FULL_CNT);
        fifo_empty  = (count_q == '0);
        status_word = {55'd0, ovf_q, 1'b0, 5'(count_q), fifo_empty, fifo_full};

        // In IDLE the request has not been latched yet, so decode straight off the bus.
        cur_off = (state_q == ST_IDLE) ? mem_addr[4:3] : off_q;
        cur_wr  = (state_q == ST_IDLE) ? mem_dout_write : wr_q;

        read_val = '0;
        case (cur_off)
            OFF_SCRATCH: read_val = scratch_q;
            OFF_TIMER:   read_val = timer_q;
            OFF_TX:      read_val = '0;
            OFF_STATUS:  read_val = status_word;
            default:     read_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    off_d   = mem_addr[4:3];
                    wr_d    = mem_dout_write;
                    wdata_d = mem_dout;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        rdata_d = cur_wr ? '0 : read_val;
                    end else begin
                        state_d = ST_WAIT;
                        wait_d  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_ACK;
                    rdata_d = cur_wr ? '0 : read_val;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_TURN;
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        commit   = (state_q == ST_ACK) && wr_q;
        push_req = commit && (off_q == OFF_TX);
        push     = push_req && !fifo_full;
        pop      = !fifo_empty && tx_ready;

        scratch_d = scratch_q;
        if (commit && (off_q == OFF_SCRATCH)) begin
            scratch_d = wdata_q;
        end

        timer_d = timer_q + 64'd1;
        if (commit && (off_q == OFF_TIMER)) begin
            timer_d = wdata_q;
        end

        // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
        ovf_d = ovf_q;
        if (commit && (off_q == OFF_STATUS) && wdata_q[8]) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = wdata_q[7:0];
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            off_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            wait_q    <= '0;
            rdata_q   <= '0;
            scratch_q <= '0;
            timer_q   <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            rdata_q    <= rdata_d;
            scratch_q  <= scratch_d;
            timer_q    <= timer_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign mem_din       = rdata_q;
    assign mem_din_ready = (state_q == ST_ACK);
    assign tx_valid      = !fifo_empty;
    assign tx_data       = fifo_empty ? 8'd0 : fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed plus randomized bus accesses against a behavioural model
// of the register file, timer and TX byte queue.
module tb_io_responder;

    localparam logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_FF00;
    localparam int          WS    = 1;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_dout = '0;
    logic        mem_dout_write = 1'b0;
    logic        mem_addr_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [63:0] mem_din;
    logic        mem_din_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [63:0] mem_din0;
    logic        mem_din_ready0;
    logic [7:0]  tx_data0;
    logic        tx_valid0;

    io_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_dout_write(mem_dout_write), .mem_addr_valid(mem_addr_valid),
        .mem_din(mem_din), .mem_din_ready(mem_din_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // Zero-wait-state instance sharing the same bus, used for the back-to-back select check.
    io_responder #(.BASE_ADDR(BASE), .WAIT_STATES(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_dout_write(mem_dout_write), .mem_addr_valid(mem_addr_valid),
        .mem_din(mem_din0), .mem_din_ready(mem_din_ready0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_scratch = '0;
    logic [63:0] m_timer_base = '0;
    int unsigned m_timer_cyc = 0;
    logic        m_ovf = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        int n = exp_q.size();
        return {55'd0, m_ovf, 1'b0, 5'(n), (n == 0), (n == DEPTH)};
    endfunction

    // Reads see register state in the last wait cycle, i.e. cycle t+WS.
    function automatic logic [63:0] model_read(input logic [1:0] off, input int unsigned t);
        case (off)
            2'd0:    return m_scratch;
            2'd1:    return m_timer_base + 64'(t + WS - m_timer_cyc);
            2'd2:    return 64'd0;
            default: return model_status();
        endcase
    endfunction

    task automatic model_write(input logic [1:0] off, input logic [63:0] d, input int unsigned t);
        case (off)
            2'd0: m_scratch = d;
            2'd1: begin m_timer_base = d; m_timer_cyc = t + 2 + WS; end
            2'd2: if (exp_q.size() == DEPTH) m_ovf = 1'b1; else exp_q.push_back(d[7:0]);
            default: if (d[8]) m_ovf = 1'b0;
        endcase
    endtask

    task automatic model_reset();
        m_scratch    = '0;
        m_timer_base = '0;
        m_timer_cyc  = cyc;
        m_ovf        = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Called #1 after a rising edge with the responder idle; returns #1 after the edge ending TURN.
    task automatic access(input logic [63:0] a, input logic w, input logic [63:0] d,
                          output logic [63:0] rd, output int lat, output int unsigned t);
        t = cyc;
        mem_addr = a; mem_dout_write = w; mem_dout = d; mem_addr_valid = 1'b1;
        @(posedge clk); #1;
        mem_addr_valid = 1'b0; mem_dout_write = 1'b0;
        lat = -1; rd = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_din_ready) begin lat = k; rd = mem_din; end
        end
        @(negedge clk);
        chk("turn_ready", 64'(mem_din_ready), 64'd0);
        chk("turn_din", mem_din, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_rw(input logic [1:0] off, input logic w, input logic [63:0] d,
                         input string tag, output logic [63:0] rd);
        logic [63:0] a;
        int lat;
        int unsigned t;
        a = BASE | {59'd0, off, 3'($urandom_range(0, 7))};
        access(a, w, d, rd, lat, t);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        if (w) model_write(off, d, t);
        else chk({tag, "_rd"}, rd, model_read(off, t));
    endtask

    task automatic drain(input int k);
        int n;
        tx_ready = 1'b1;
        repeat (k) @(posedge clk);
        #1 tx_ready = 1'b0;
        n = (k < exp_q.size()) ? k : exp_q.size();
        chk("drain_cnt", 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) chk("drain_byte", 64'(got_q[i]), 64'(exp_q[i]));
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        got_q.delete();
    endtask

    task automatic chk_tx(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(tx_valid), 64'(exp_q.size() != 0));
        chk({tag, "_data"}, 64'(tx_data), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] d;
        int          r;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(mem_din_ready), 64'd0);
        chk("rst_din", mem_din, 64'd0);
        chk("rst_txv", 64'(tx_valid), 64'd0);
        chk("rst_txd", 64'(tx_data), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();

        // scratch write then read
        do_rw(2'd0, 1'b1, 64'hDEAD_BEEF_0123_4567, "scr_wr", rd);
        do_rw(2'd0, 1'b0, 64'd0, "scr_rd", rd);
        chk("scr_const", rd, 64'hDEAD_BEEF_0123_4567);

        // timer load followed immediately by a read
        do_rw(2'd1, 1'b1, 64'h100, "tmr_wr", rd);
        do_rw(2'd1, 1'b0, 64'd0, "tmr_rd", rd);
        chk("tmr_const", rd, 64'h102);
        do_rw(2'd2, 1'b0, 64'd0, "txd_rd", rd);

        // fill past full, check overflow, clear it, drain
        for (int i = 0; i < 9; i++) do_rw(2'd2, 1'b1, 64'h41 + 64'(i), "fifo_push", rd);
        do_rw(2'd3, 1'b0, 64'd0, "st_full", rd);
        chk("st_full_const", rd, 64'h121);
        chk_tx("head41");
        do_rw(2'd3, 1'b1, 64'h100, "st_clr", rd);
        do_rw(2'd3, 1'b0, 64'd0, "st_clr_rd", rd);
        chk("st_clr_const", rd, 64'h021);
        drain(8);
        do_rw(2'd3, 1'b0, 64'd0, "st_empty", rd);
        chk("st_empty_const", rd, 64'h002);

        // timer wrap
        do_rw(2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "wrap_wr", rd);
        do_rw(2'd1, 1'b0, 64'd0, "wrap_rd", rd);

        // out of window, then in-window with valid low: no acknowledge, no side effect
        mem_addr = 64'h10; mem_dout_write = 1'b1; mem_dout = 64'h77; mem_addr_valid = 1'b1;
        repeat (5) begin @(negedge clk); chk("oow_ready", 64'(mem_din_ready), 64'd0); end
        @(posedge clk); #1;
        mem_addr = BASE | 64'h10; mem_addr_valid = 1'b0;
        repeat (5) begin @(negedge clk); chk("nov_ready", 64'(mem_din_ready), 64'd0); end
        @(posedge clk); #1 mem_dout_write = 1'b0;
        do_rw(2'd3, 1'b0, 64'd0, "oow_st", rd);
        do_rw(2'd0, 1'b0, 64'd0, "oow_scr", rd);

        // randomized accesses and drains
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            d = {$urandom, $urandom};
            if (r <= 7) do_rw(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, "rnd", rd);
            else if (r == 8) drain($urandom_range(1, 10));
            else chk_tx("rnd_tx");
        end
        drain(DEPTH + 1);

        // reset during the wait state of a scratch write
        do_rw(2'd2, 1'b1, 64'h5A, "pre_rst_push", rd);
        mem_addr = BASE; mem_dout_write = 1'b1; mem_dout = 64'h55; mem_addr_valid = 1'b1;
        @(posedge clk); #1;
        mem_addr_valid = 1'b0; mem_dout_write = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_wait_ready", 64'(mem_din_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_ready", 64'(mem_din_ready), 64'd0);
        chk("mid_din", mem_din, 64'd0);
        chk("mid_txv", 64'(tx_valid), 64'd0);
        chk("mid_txd", 64'(tx_data), 64'd0);
        @(posedge clk); #1;
        do_rw(2'd0, 1'b0, 64'd0, "mid_scr", rd);
        chk("mid_scr_const", rd, 64'd0);
        do_rw(2'd3, 1'b0, 64'd0, "mid_st", rd);

        // select held for 12 cycles on the zero-wait-state instance
        mem_addr = BASE; mem_dout_write = 1'b0; mem_addr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("held_ready0", 64'(mem_din_ready0), 64'((k % 3) == 1));
        end
        @(posedge clk); #1 mem_addr_valid = 1'b0;
        @(negedge clk);
        chk("held_idle_txv0", 64'(tx_valid0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped IO target on the Raisin64 external data bus: the responder end of the `mem_addr`/`mem_dout`/`mem_dout_write`/`mem_din`/`mem_din_ready` interface driven by the CPU top level. It decodes a 32-byte window at `BASE_ADDR` and serves four 64-bit registers: scratch, free-running timer, console TX FIFO push, and status. Every access is acknowledged with a single-cycle `mem_din_ready` pulse after a programmable number of wait states. A ready/valid byte stream drains the TX FIFO toward a UART transmitter.

## Interface
Parameters:
- `BASE_ADDR`, default 64'hFFFF_FFFF_FFFF_FF00. Window base; bits [4:0] are ignored.
- `WAIT_STATES`, default 1. Range 0..15. Cycles inserted between request acceptance and acknowledge.
- `FIFO_DEPTH`, default 8. TX FIFO depth; must be a power of two, 2..16.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  in  64  byte address from CPU.
- `mem_dout`  in  64  write data from CPU.
- `mem_dout_write`  in  1  write strobe; 1 = write, 0 = read.
- `mem_addr_valid`  in  1  address qualifier.
- `mem_din`  out  64  read data to CPU; valid only while `mem_din_ready` = 1.
- `mem_din_ready`  out  1  one-cycle acknowledge.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  sink accepts the head byte.

## Operation
- Select: `sel = mem_addr_valid & (mem_addr[63:5] == BASE_ADDR[63:5])`. Register offset is `mem_addr[4:3]`; `mem_addr[2:0]` is ignored.
- FSM states: IDLE, WAIT, ACK, TURN.
  - IDLE: on `sel`, latch offset, `mem_dout_write`, and `mem_dout`. Go to WAIT if `WAIT_STATES` > 0, else go to ACK.
  - WAIT: count `WAIT_STATES` cycles, then go to ACK.
  - ACK: `mem_din_ready` = 1 for exactly one cycle. Commit any write at the clock edge that ends ACK. Go to TURN.
  - TURN: one cycle; `sel` is ignored. Go to IDLE.
- A request still present in the IDLE cycle after TURN is a new access. The initiator must drop or change the request within the ACK+TURN window.
- Register map (offset):
  - 0x00 SCRATCH: read/write, reset 0.
  - 0x08 TIMER: 64-bit counter, +1 every cycle, wraps to 0 after all-ones. A write loads `mem_dout`; the load takes precedence over the increment on that edge.
  - 0x10 TX_DATA: a write pushes `mem_dout[7:0]`. A read returns 0.
  - 0x18 STATUS, read-only fields:
    - [0] full
    - [1] empty
    - [6:2] count
    - [8] ovf (sticky)
    - A write with `mem_dout[8]` = 1 clears ovf. Other write bits are ignored.
- Read data is captured at the clock edge entering ACK and reflects register state in the last WAIT cycle (or the IDLE cycle when `WAIT_STATES` = 0). `mem_din` = 0 outside ACK.
- TX FIFO:
  - Push happens at the ACK-end edge.
  - If the FIFO is full in the ACK cycle, the push is dropped and ovf is set. This holds even if a pop happens on the same edge.
  - Pop when `tx_valid & tx_ready`.
  - Push and pop on the same edge, not full: count is unchanged.
  - `tx_data` shows the head entry, and 0 when empty.
- The window is 32 bytes, so every offset is defined. Any in-window access is acknowledged.

## Timing
- Request sampled in IDLE at cycle T. `mem_din_ready` is high in cycle T+1+`WAIT_STATES`. Minimum access-to-access spacing is `WAIT_STATES`+3 cycles.
- Writes become visible to reads from cycle ACK+1.
- `tx_valid` rises the cycle after the push edge.
- Reset values:
  - `mem_din` = 0, `mem_din_ready` = 0.
  - `tx_valid` = 0, `tx_data` = 0.
  - FSM = IDLE; TIMER, SCRATCH, and ovf = 0; FIFO empty.
- Reset mid-access (WAIT or ACK): the access is abandoned, no write commits, and `mem_din_ready` is 0 the next cycle.
- Reset has priority over all other events.

## Test plan
- `WAIT_STATES`=1: write SCRATCH 0xDEAD_BEEF_0123_4567, then read it → one ready pulse, exactly 2 cycles after each request; read returns 0xDEAD_BEEF_0123_4567.
- Write TIMER 0x100 (ACK at cycle A), with the next read request at A+2, `WAIT_STATES`=1 → `mem_din` = 0x102 in cycle A+4.
- With `tx_ready`=0, push 9 bytes 0x41..0x49 → STATUS = 0x121 (full, count 8, ovf); `tx_data` = 0x41. Write STATUS with bit 8 set → ovf = 0. Raise `tx_ready` → bytes 0x41..0x48 drain in order, one per cycle; then STATUS = 0x002.
- `sel` held continuously for 12 cycles with `WAIT_STATES`=0 → `mem_din_ready` pulses every 3 cycles, never on consecutive cycles.
- Address outside the window (e.g. 0x0000_0000_0000_0010) → no ready, no state change. `mem_addr_valid`=0 while the address is in-window → no ready.
- Assert `rst` during the WAIT of a SCRATCH write of 0x55 → SCRATCH reads 0, no ready pulse occurs, and all outputs are 0 the cycle after reset.
